// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter: ALU results take priority over a FIFO of load returns.
// Optional load scoreboard (busy / WAW detect) compiled in with WB_SCOREBOARD_EN.
module writeback_arbiter #(
   parameter int DW    = 19,
   parameter int AW    = 4,
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 alu_valid,
   input  logic [AW-1:0]        alu_rd,
   input  logic [DW-1:0]        alu_data,
   input  logic                 mem_valid,
   input  logic [AW-1:0]        mem_rd,
   input  logic [DW-1:0]        mem_data,
   output logic                 mem_ready,
   input  logic                 load_issue,
   input  logic [AW-1:0]        load_rd,
   output logic                 WE3,
   output logic [AW-1:0]        A3,
   output logic [DW-1:0]        WD3,
   output logic [(1<<AW)-1:0]   busy,
   output logic                 waw_err
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   logic [AW-1:0] q_rd   [DEPTH];
   logic [DW-1:0] q_data [DEPTH];
   logic [PW-1:0] wptr, rptr;
   logic [PW:0]   count;

   logic          push, pop, sel_vld;
   logic [AW-1:0] sel_rd;
   logic [DW-1:0] sel_data;

   assign mem_ready = (count < FULL);
   assign push      = mem_valid && mem_ready;

   always_comb begin
      pop      = 1'b0;
      sel_vld  = 1'b0;
      sel_rd   = alu_rd;
      sel_data = alu_data;
      if (alu_valid) begin
         sel_vld = 1'b1;
      end else if (count != '0) begin
         sel_vld  = 1'b1;
         pop      = 1'b1;
         sel_rd   = q_rd[rptr];
         sel_data = q_data[rptr];
      end
   end

   // Storage needs no reset: entries are only read when count says they are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         q_rd[wptr]   <= mem_rd;
         q_data[wptr] <= mem_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // r0 writes are swallowed here; A3/WD3 keep their last values when idle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         WE3 <= 1'b0;
         A3  <= '0;
         WD3 <= '0;
      end else if (sel_vld && sel_rd != '0) begin
         WE3 <= 1'b1;
         A3  <= sel_rd;
         WD3 <= sel_data;
      end else begin
         WE3 <= 1'b0;
      end
   end

`ifdef WB_SCOREBOARD_EN
   logic                wb_fifo;
   logic [(1<<AW)-1:0]  set_m, clr_m;

   always_comb begin
      set_m = '0;
      clr_m = '0;
      if (load_issue) set_m[load_rd] = 1'b1;
      if (WE3 && wb_fifo) clr_m[A3] = 1'b1;
      set_m[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wb_fifo <= 1'b0;
         busy    <= '0;
         waw_err <= 1'b0;
      end else begin
         wb_fifo <= pop && sel_rd != '0;
         busy    <= ((busy & ~clr_m) | set_m) & ~((1<<AW)'(1));
         if (alu_valid && alu_rd != '0 && busy[alu_rd]) waw_err <= 1'b1;
      end
   end
`else
   logic unused_sb;
   assign unused_sb = ^{load_issue, load_rd};
   assign busy      = '0;
   assign waw_err   = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter (default parameters).
module tb_writeback_arbiter;
   localparam int DW = 19, AW = 4, DEPTH = 4;

   logic clk = 1'b0, rst = 1'b0;
   logic alu_valid = 0, mem_valid = 0, load_issue = 0;
   logic [AW-1:0] alu_rd = 0, mem_rd = 0, load_rd = 0;
   logic [DW-1:0] alu_data = 0, mem_data = 0;
   logic mem_ready, WE3, waw_err;
   logic [AW-1:0] A3;
   logic [DW-1:0] WD3;
   logic [(1<<AW)-1:0] busy;
   int n_chk = 0, n_pass = 0;

   writeback_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
      .mem_ready(mem_ready), .load_issue(load_issue), .load_rd(load_rd),
      .WE3(WE3), .A3(A3), .WD3(WD3), .busy(busy), .waw_err(waw_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_valid = 0; mem_valid = 0; load_issue = 0;
   endtask

   initial begin
      idle();
      tick(); tick();
      rst = 1;
      chk("rst_we3", WE3, 0);
      chk("rst_a3", A3, 0);
      chk("rst_wd3", WD3, 0);
      chk("rst_busy", busy, 0);
      chk("rst_waw", waw_err, 0);
      chk("rst_ready", mem_ready, 1);

      // ALU path
      alu_valid = 1; alu_rd = 3; alu_data = 19'h12345;
      tick(); idle();
      chk("alu_we3", WE3, 1);
      chk("alu_a3", A3, 3);
      chk("alu_wd3", WD3, 32'h12345);
      tick();
      chk("alu_we3_off", WE3, 0);
      chk("alu_a3_hold", A3, 3);

      // ALU vs load priority
      alu_valid = 1; alu_rd = 5; alu_data = 19'h00011;
      mem_valid = 1; mem_rd = 6; mem_data = 19'h7FFFF;
      tick(); idle();
      chk("pri_a3_n1", A3, 5);
      chk("pri_wd3_n1", WD3, 32'h11);
      chk("pri_we3_n1", WE3, 1);
      chk("pri_ready", mem_ready, 1);
      tick();
      chk("pri_we3_n2", WE3, 1);
      chk("pri_a3_n2", A3, 6);
      chk("pri_wd3_n2", WD3, 32'h7FFFF);
      tick();
      chk("pri_we3_n3", WE3, 0);

      // Fill FIFO behind a continuous ALU stream; 5th return dropped
      alu_valid = 1; alu_rd = 1; alu_data = 19'h00777;
      for (int i = 0; i < 5; i++) begin
         mem_valid = 1; mem_rd = AW'(2 + i); mem_data = DW'(32'h100 + i);
         chk($sformatf("full_ready%0d", i), mem_ready, (i < 4) ? 1 : 0);
         tick();
         chk($sformatf("full_alu%0d", i), A3, 1);
      end
      idle();
      chk("full_ready_hold", mem_ready, 0);
      for (int j = 0; j < 4; j++) begin
         tick();
         chk($sformatf("drain_we3_%0d", j), WE3, 1);
         chk($sformatf("drain_a3_%0d", j), A3, 2 + j);
         chk($sformatf("drain_wd3_%0d", j), WD3, 32'h100 + j);
         chk($sformatf("drain_ready_%0d", j), mem_ready, 1);
      end
      tick();
      chk("drain_empty", WE3, 0);

      // r0 discard on both sources
      alu_valid = 1; alu_rd = 0; alu_data = 19'h00abc;
      mem_valid = 1; mem_rd = 0; mem_data = 19'h00def;
      tick(); idle();
      chk("r0_alu", WE3, 0);
      tick();
      chk("r0_mem", WE3, 0);
      chk("r0_ready", mem_ready, 1);
      tick();
      chk("r0_idle", WE3, 0);

      // Load latency into empty FIFO: N+2 (also shows FIFO is empty again)
      mem_valid = 1; mem_rd = 9; mem_data = 19'h0aaaa;
      tick(); idle();
      chk("lat_n1", WE3, 0);
      tick();
      chk("lat_n2_we3", WE3, 1);
      chk("lat_n2_a3", A3, 9);
      chk("lat_n2_wd3", WD3, 32'haaaa);
      tick();

`ifdef WB_SCOREBOARD_EN
      load_issue = 1; load_rd = 7;
      tick(); idle();
      chk("sb_busy_set", busy, 32'h80);
      alu_valid = 1; alu_rd = 7; alu_data = 19'h00055;
      tick(); idle();
      chk("sb_waw", waw_err, 1);
      chk("sb_alu_we3", WE3, 1);
      chk("sb_busy_keep", busy, 32'h80);
      mem_valid = 1; mem_rd = 7; mem_data = 19'h00066;
      tick(); idle();
      tick();
      chk("sb_ld_we3", WE3, 1);
      chk("sb_ld_a3", A3, 7);
      chk("sb_busy_pre", busy, 32'h80);
      tick();
      chk("sb_busy_clr", busy, 0);
      chk("sb_waw_sticky", waw_err, 1);
      load_issue = 1; load_rd = 0;
      tick(); idle();
      chk("sb_r0", busy, 0);
`else
      load_issue = 1; load_rd = 7;
      tick(); idle();
      chk("nosb_busy", busy, 0);
      alu_valid = 1; alu_rd = 7; alu_data = 19'h00055;
      tick(); idle();
      chk("nosb_waw", waw_err, 0);
      chk("nosb_we3", WE3, 1);
`endif

      // Reset mid-operation with 3 buffered entries and conflicting inputs
      alu_valid = 1; alu_rd = 1; alu_data = 19'h00001;
      load_issue = 1; load_rd = 10;
      for (int i = 0; i < 3; i++) begin
         mem_valid = 1; mem_rd = AW'(10 + i); mem_data = DW'(32'h200 + i);
         tick();
      end
      rst = 0;
      alu_rd = 13; mem_rd = 14; load_rd = 12;
      tick();
      rst = 1; idle();
      chk("mrst_we3", WE3, 0);
      chk("mrst_a3", A3, 0);
      chk("mrst_wd3", WD3, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_waw", waw_err, 0);
      chk("mrst_ready", mem_ready, 1);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("mrst_quiet%0d", k), WE3, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 19, register data width.
REQ-002 The block SHALL have parameter AW, default 4, register address width.
REQ-003 The block SHALL have parameter DEPTH, default 4, load-return FIFO entries, power of two, at least 2.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset, synchronous and active-low.
REQ-006 The block SHALL have ports alu_valid (in, 1), alu_rd (in, AW) and alu_data (in, DW), the ALU result write request.
REQ-007 The block SHALL have ports mem_valid (in, 1), mem_rd (in, AW) and mem_data (in, DW), the load return.
REQ-008 The block SHALL have port mem_ready, output, 1, high when the FIFO can accept a load return.
REQ-009 The block SHALL have ports load_issue (in, 1) and load_rd (in, AW), marking a load issued to a destination.
REQ-010 The block SHALL have ports WE3 (out, 1), A3 (out, AW) and WD3 (out, DW), the register file write port.
REQ-011 The block SHALL have port busy, output, 2^AW bits, where bit i high means a load to register i is pending.
REQ-012 The block SHALL have port waw_err, output, 1, a sticky flag for an ALU write to a busy register.

Function
REQ-013 A load return SHALL be accepted only on a cycle where mem_valid and mem_ready are both high.
- An accepted return is pushed into the FIFO.
- A return offered while mem_ready is low is ignored.
REQ-014 mem_ready SHALL equal (FIFO count < DEPTH), decoded from registered state.
REQ-015 Each cycle, the block SHALL select one write source.
- alu_valid high: ALU request is selected and the FIFO is not popped.
- Otherwise, FIFO not empty: FIFO head is selected and popped.
- Otherwise: no source is selected.
REQ-016 The output registers SHALL load as follows on each edge.
- A source is selected with rd != 0: WE3 <= 1, A3 <= rd, WD3 <= data.
- Otherwise: WE3 <= 0, and A3/WD3 hold their values.
REQ-017 Writes with rd == 0 SHALL be consumed (FIFO popped if that was the source) without ever asserting WE3.
REQ-018 Latency SHALL be fixed.
- ALU request in cycle N appears on WE3 in cycle N+1.
- Load return accepted into an empty FIFO in cycle N, with no ALU request in N+1, appears on WE3 in cycle N+2.
REQ-019 The FIFO SHALL be a circular buffer of DEPTH entries whose read/write pointers wrap modulo DEPTH.
- A push and a pop in the same cycle SHALL leave the count unchanged.
- Entries SHALL drain in the order they were accepted.
REQ-020 Scoreboard behaviour:
- load_issue high with load_rd != 0 sets busy[load_rd].
- A write of register r on WE3 clears busy[r] at the next edge, but only if the write came from the FIFO.
- A set and a clear of the same bit in the same cycle SHALL resolve with set winning.
REQ-021 If alu_valid is high with alu_rd != 0 and busy[alu_rd] is high, waw_err SHALL be set on the next edge and held until reset.
- The ALU write still proceeds.
REQ-022 busy[0] SHALL always read 0.

Reset
REQ-023 While rst is low at a clock edge, the block SHALL reset to a defined state.
- Outputs: WE3=0, A3=0, WD3=0, busy=0, waw_err=0.
- FIFO: emptied, pointers at 0, count at 0.
- mem_ready is therefore 1 in the next cycle.
REQ-024 Reset SHALL override any simultaneous ALU request, load return or load_issue.
- Reset mid-drain SHALL discard every buffered entry, with no write emitted in the cycle after reset.

Configuration
REQ-025 Macro WB_SCOREBOARD_EN SHALL control whether the scoreboard is compiled in.
- Defined: REQ-020, REQ-021 and REQ-022 apply.
- Undefined: busy is tied to 0, waw_err is tied to 0, and load_issue/load_rd are ignored.
- All other behaviour is identical, and the port list is unchanged either way.

Verification
REQ-026 ALU path: after reset, alu_valid=1, alu_rd=3, alu_data=19'h12345 for one cycle -> next cycle WE3=1, A3=3, WD3=19'h12345; the cycle after that, WE3=0.
REQ-027 Priority: ALU (rd=5, data 19'h00011) and mem (rd=6, data 19'h7FFFF) both valid in the same cycle -> r5 is written in N+1, r6 in N+2, mem_ready stays 1.
REQ-028 Full FIFO: hold alu_valid=1 (rd=1) while offering 5 load returns rd=2..6 on consecutive cycles.
- Expected: first 4 accepted, mem_ready=0 on the 5th, which is dropped.
- Then release ALU: r2, r3, r4, r5 written in order on 4 consecutive cycles, and mem_ready returns to 1 after the first pop.
REQ-029 r0 discard: ALU rd=0 and a load return rd=0 -> WE3 never asserts and the FIFO returns to empty.
REQ-030 Scoreboard (WB_SCOREBOARD_EN defined): load_issue rd=7 -> busy[7]=1; ALU write rd=7 -> waw_err=1, busy[7] still 1; load return rd=7 written -> busy[7]=0, waw_err stays 1.
REQ-031 Reset mid-operation: FIFO holding 3 entries, drive rst=0 for one edge -> WE3=0, busy=0, mem_ready=1, and no further writes without new stimulus.
